// File: rtl/cover_collect_pkg.sv
// Shared types and helpers for the coverage hit collector.
package cover_collect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CLEAR
    } state_e;

    localparam int WORD_W     = 64;
    localparam int WORD_BIT_W = $clog2(WORD_W);

    function automatic int words_for(input int total);
        return (total + WORD_W - 1) / WORD_W;
    endfunction

    // Scanning from the top down leaves the lowest set position in pos.
    function automatic logic [WORD_BIT_W-1:0] lowest_set(input logic [WORD_W-1:0] v);
        logic [WORD_BIT_W-1:0] pos;
        pos = '0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            if (v[i]) pos = WORD_BIT_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/cover_hit_fifo.sv
// Synchronous FIFO for newly covered indices; reads as zero when empty.
module cover_hit_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;
    logic          do_push;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees the slot first, so a push on a full FIFO still lands.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cover_hit_collector.sv
// Coverage hit collector: ever-hit bitmap, emits each newly covered index once.
// Optional COVER_HIT_CYCLE_EN adds a cycle stamp (out_cycle) to every emitted index.
module cover_hit_collector
    import cover_collect_pkg::*;
#(
    parameter int COVER_TOTAL = 8940,
    parameter int WIDTH       = 7,
    parameter int FIFO_DEPTH  = 16,
    parameter int IDX_W       = $clog2(COVER_TOTAL)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_base,
    input  logic [WIDTH-1:0] in_hits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic [IDX_W:0]   hit_count,
`ifdef COVER_HIT_CYCLE_EN
    output logic [31:0]      out_cycle,
`endif
    output logic             overflow
);

    localparam int WORDS   = words_for(COVER_TOTAL);
    localparam int WADDR_W = $clog2(WORDS);
`ifdef COVER_HIT_CYCLE_EN
    localparam int DW = IDX_W + 32;
`else
    localparam int DW = IDX_W;
`endif

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    pend_q, pend_d;
    logic [IDX_W-1:0]    base_q, base_d;
    logic                clear_pend_q, clear_pend_d;
    logic [WADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [IDX_W:0]      hit_count_q, hit_count_d;
    logic                overflow_q, overflow_d;
    logic [WORD_W-1:0]   bitmap_q [WORDS];
    logic [WORD_W-1:0]   bitmap_d [WORDS];

    logic [WORD_BIT_W-1:0] bit_sel;
    logic [IDX_W:0]        idx;
    logic [WADDR_W-1:0]    word_addr;
    logic [WORD_BIT_W-1:0] word_bit;
    logic                  accept;
    logic                  push;
    logic                  flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DW-1:0]         push_data;
    logic [DW-1:0]         pop_data;

    assign in_ready   = reset && (state_q == IDLE) && !clear_pend_q;
    assign accept     = in_valid && in_ready;
    assign clear_busy = (state_q == CLEAR);
    assign hit_count  = hit_count_q;
    assign overflow   = overflow_q;
    assign out_valid  = !fifo_empty;
    assign out_index  = pop_data[IDX_W-1:0];

    assign bit_sel   = lowest_set(WORD_W'(pend_q));
    assign idx       = {1'b0, base_q} + (IDX_W+1)'(bit_sel);
    assign word_addr = WADDR_W'(idx >> WORD_BIT_W);
    assign word_bit  = idx[WORD_BIT_W-1:0];

`ifdef COVER_HIT_CYCLE_EN
    logic [31:0] cycle_q, cycle_d;
    assign cycle_d   = cycle_q + 32'd1;
    assign push_data = {cycle_q, idx[IDX_W-1:0]};
    assign out_cycle = pop_data[IDX_W +: 32];

    always_ff @(posedge clock) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_d;
    end
`else
    assign push_data = idx[IDX_W-1:0];
`endif

    // A clear arriving with an accepted beat waits in clear_pend until the beat is done.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        base_d       = base_q;
        clear_pend_d = clear_pend_q;
        clr_addr_d   = clr_addr_q;
        hit_count_d  = hit_count_q;
        overflow_d   = overflow_q;
        bitmap_d     = bitmap_q;
        push         = 1'b0;
        flush        = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_pend_q || (clear_req && !accept)) begin
                    state_d      = CLEAR;
                    clear_pend_d = 1'b0;
                    clr_addr_d   = '0;
                    flush        = 1'b1;
                    hit_count_d  = '0;
                    overflow_d   = 1'b0;
                end else if (accept) begin
                    pend_d       = in_hits;
                    base_d       = in_base;
                    clear_pend_d = clear_req;
                    if (in_hits != '0) state_d = SCAN;
                end
            end
            SCAN: begin
                pend_d = pend_q & ~(WIDTH'(1) << bit_sel);
                if (clear_req) clear_pend_d = 1'b1;
                if (idx >= (IDX_W+1)'(COVER_TOTAL)) begin
                    overflow_d = 1'b1;
                end else if (!bitmap_q[word_addr][word_bit]) begin
                    bitmap_d[word_addr][word_bit] = 1'b1;
                    hit_count_d = hit_count_q + (IDX_W+1)'(1);
                    if (fifo_full && !out_ready) overflow_d = 1'b1;
                    else                         push       = 1'b1;
                end
                if (pend_d == '0) state_d = IDLE;
            end
            CLEAR: begin
                bitmap_d[clr_addr_q] = '0;
                if (clr_addr_q == WADDR_W'(WORDS - 1)) state_d = IDLE;
                else                                   clr_addr_d = clr_addr_q + WADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            base_q       <= '0;
            clear_pend_q <= 1'b0;
            clr_addr_q   <= '0;
            hit_count_q  <= '0;
            overflow_q   <= 1'b0;
            bitmap_q     <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            base_q       <= base_d;
            clear_pend_q <= clear_pend_d;
            clr_addr_q   <= clr_addr_d;
            hit_count_q  <= hit_count_d;
            overflow_q   <= overflow_d;
            bitmap_q     <= bitmap_d;
        end
    end

    cover_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
